// File: rtl/frame_buffer_multibank.sv
// Multi-bank frame store. A writer fills one bank while a reader consumes another.
// The banks form a small frame FIFO: the writer commits a finished bank and the reader
// releases it once the frame has been consumed. Pixel storage is a single array
// addressed as {bank, pixel_addr} with an enable-gated registered read. This keeps the
// array free of reset so that it maps onto block RAM.
module frame_buffer_multibank #(
  parameter int IMG_WIDTH   = 1280,
  parameter int IMG_HEIGHT  = 720,
  parameter int PIXEL_BITS  = 24,
  parameter int NUM_BANKS   = 2,
  parameter int RD_LATENCY  = 1,
  localparam int FRAME_DEPTH = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW          = $clog2(FRAME_DEPTH),
  localparam int BW          = $clog2(NUM_BANKS),
  localparam int CW          = $clog2(NUM_BANKS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         wr_addr,
  input  logic [PIXEL_BITS-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_frame_done,
  output logic                  wr_ready,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_en,
  input  logic                  rd_frame_done,
  output logic                  rd_frame_valid,
  output logic [PIXEL_BITS-1:0] rd_data,
  output logic                  rd_valid,
  output logic [CW-1:0]         frames_stored,
  output logic [15:0]           wr_drop_cnt
);

  localparam int              MEM_DEPTH = NUM_BANKS * (2 ** AW);
  localparam logic [AW:0]     DEPTH_LIM = (AW + 1)'(FRAME_DEPTH);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(NUM_BANKS);

  logic [BW-1:0] wr_bank_reg, wr_bank_next;
  logic [BW-1:0] rd_bank_reg, rd_bank_next;
  logic [CW-1:0] frames_reg, frames_next;
  logic [15:0]   drop_reg, drop_next;

  logic wr_in_range, rd_in_range;
  logic wr_fire, wr_drop, rd_issue;
  logic commit_fire, rel_fire;

  logic [PIXEL_BITS-1:0] mem [0:MEM_DEPTH-1];
  logic [PIXEL_BITS-1:0] mem_q;
  logic                  rd_valid1_reg;
  logic                  rd_oor1_reg;

  assign wr_ready       = (frames_reg < FULL_CNT);
  assign rd_frame_valid = (frames_reg != '0);
  assign frames_stored  = frames_reg;
  assign wr_drop_cnt    = drop_reg;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
  assign wr_fire     = wr_en & wr_ready & wr_in_range;
  assign wr_drop     = wr_en & ~wr_ready;
  assign rd_issue    = rd_en & rd_frame_valid;

  // Handshake validity is judged on the pre-edge count, so at full a commit is
  // refused while a simultaneous release still goes through.
  assign commit_fire = wr_frame_done & wr_ready;
  assign rel_fire    = rd_frame_done & rd_frame_valid;

  // Next-state for the bank pointers, frame count and saturating drop counter.
  always_comb begin
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    frames_next  = frames_reg;
    drop_next    = drop_reg;
    if (commit_fire) begin
      wr_bank_next = wr_bank_reg + BW'(1);
    end
    if (rel_fire) begin
      rd_bank_next = rd_bank_reg + BW'(1);
    end
    case ({commit_fire, rel_fire})
      2'b10:   frames_next = frames_reg + CW'(1);
      2'b01:   frames_next = frames_reg - CW'(1);
      default: frames_next = frames_reg;
    endcase
    if (wr_drop && (drop_reg != 16'hFFFF)) begin
      drop_next = drop_reg + 16'd1;
    end
  end

  // Control state register; reset discards any partially written or committed frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_reg <= '0;
      rd_bank_reg <= '0;
      frames_reg  <= '0;
      drop_reg    <= '0;
    end else begin
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      frames_reg  <= frames_next;
      drop_reg    <= drop_next;
    end
  end

  // Pixel array: write port plus enable-gated registered read (no reset, block RAM friendly).
  // The read bank is captured here at issue, so a release in the same cycle cannot
  // redirect a read that has already been accepted.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank_reg, wr_addr}] <= wr_data;
    end
    if (rd_issue) begin
      mem_q <= mem[{rd_bank_reg, rd_addr}];
    end
  end

  // First read stage control: valid flag and out-of-range marker travel with mem_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid1_reg <= 1'b0;
      rd_oor1_reg   <= 1'b0;
    end else begin
      rd_valid1_reg <= rd_issue;
      if (rd_issue) begin
        rd_oor1_reg <= ~rd_in_range;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [PIXEL_BITS-1:0] rd_data2_reg;
      logic                  rd_valid2_reg;

      // Output register stage; it loads only on a valid beat so data holds in between.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_data2_reg  <= '0;
          rd_valid2_reg <= 1'b0;
        end else begin
          rd_valid2_reg <= rd_valid1_reg;
          if (rd_valid1_reg) begin
            rd_data2_reg <= rd_oor1_reg ? '0 : mem_q;
          end
        end
      end

      assign rd_data  = rd_data2_reg;
      assign rd_valid = rd_valid2_reg;
    end else begin : g_lat1
      logic have_data_reg;

      // mem_q has no reset, so mask it until a read has been issued after reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          have_data_reg <= 1'b0;
        end else if (rd_issue) begin
          have_data_reg <= 1'b1;
        end
      end

      assign rd_data  = (have_data_reg && !rd_oor1_reg) ? mem_q : '0;
      assign rd_valid = rd_valid1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_frame_buffer_multibank.sv
// Bench for frame_buffer_multibank. Two instances, one with read latency 1 and one
// with read latency 2, share every input. A small reference model predicts the
// pointers, counts and pixel contents. Each issued read pushes its expected pixel
// and due cycle into a per-instance queue, and that entry is popped when rd_valid
// is due.
// The frame is 5x2 = 10 pixels, so the 4-bit address can express out-of-range values.
module tb_frame_buffer_multibank;

  localparam int W     = 5;
  localparam int H     = 2;
  localparam int PB    = 8;
  localparam int NB    = 2;
  localparam int DEPTH = W * H;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(NB + 1);

  typedef struct {
    logic [PB-1:0] data;
    int            due;
  } sb_t;

  logic          clk;
  logic          reset;
  logic [AW-1:0] wr_addr;
  logic [PB-1:0] wr_data;
  logic          wr_en;
  logic          wr_frame_done;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          rd_frame_done;

  logic          wr_ready1, rd_frame_valid1, rd_valid1;
  logic [PB-1:0] rd_data1;
  logic [CW-1:0] frames_stored1;
  logic [15:0]   wr_drop_cnt1;
  logic          wr_ready2, rd_frame_valid2, rd_valid2;
  logic [PB-1:0] rd_data2;
  logic [CW-1:0] frames_stored2;
  logic [15:0]   wr_drop_cnt2;

  int n_asserts;
  int n_fail;
  int cycle;

  sb_t q1[$];
  sb_t q2[$];
  logic [PB-1:0] last_d [2];

  logic [PB-1:0] m_mem [NB][16];
  int            m_wr, m_rd, m_cnt;
  logic [15:0]   m_drop;

  frame_buffer_multibank #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(PB), .NUM_BANKS(NB), .RD_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_frame_done(wr_frame_done),
    .wr_ready(wr_ready1),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_frame_done(rd_frame_done),
    .rd_frame_valid(rd_frame_valid1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .frames_stored(frames_stored1), .wr_drop_cnt(wr_drop_cnt1)
  );

  frame_buffer_multibank #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(PB), .NUM_BANKS(NB), .RD_LATENCY(2)
  ) u_dut2 (
    .clk(clk), .reset(reset),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_frame_done(wr_frame_done),
    .wr_ready(wr_ready2),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_frame_done(rd_frame_done),
    .rd_frame_valid(rd_frame_valid2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .frames_stored(frames_stored2), .wr_drop_cnt(wr_drop_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr   = 0;
    m_rd   = 0;
    m_cnt  = 0;
    m_drop = 16'd0;
    q1.delete();
    q2.delete();
    last_d[0] = '0;
    last_d[1] = '0;
  endtask

  // Apply the model to the inputs present before the edge, advance one clock,
  // then compare status outputs and any read beats that are due this cycle.
  task automatic tick();
    logic          m_ready, m_valid, cm, rl, v, expv, has;
    logic [PB-1:0] d;
    sb_t           e;
    if (reset) begin
      m_ready = (m_cnt < NB);
      m_valid = (m_cnt != 0);
      if (rd_en && m_valid) begin
        d = (int'(rd_addr) < DEPTH) ? m_mem[m_rd][rd_addr] : '0;
        q1.push_back('{d, cycle + 1});
        q2.push_back('{d, cycle + 2});
      end
      if (wr_en) begin
        if (!m_ready) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else if (int'(wr_addr) < DEPTH) begin
          m_mem[m_wr][wr_addr] = wr_data;
        end
      end
      cm = wr_frame_done && m_ready;
      rl = rd_frame_done && m_valid;
      if (cm) m_wr = (m_wr + 1) % NB;
      if (rl) m_rd = (m_rd + 1) % NB;
      m_cnt = m_cnt + int'(cm) - int'(rl);
    end
    @(posedge clk);
    #1;
    cycle++;
    check("frames_stored", 32'(frames_stored1), 32'(m_cnt));
    check("frames_stored lat2", 32'(frames_stored2), 32'(m_cnt));
    check("wr_ready", 32'(wr_ready1), 32'(m_cnt < NB));
    check("rd_frame_valid", 32'(rd_frame_valid1), 32'(m_cnt != 0));
    check("wr_drop_cnt", 32'(wr_drop_cnt1), 32'(m_drop));
    for (int k = 0; k < 2; k++) begin
      v   = (k == 0) ? rd_valid1 : rd_valid2;
      d   = (k == 0) ? rd_data1 : rd_data2;
      has = (k == 0) ? (q1.size() > 0) : (q2.size() > 0);
      if (has) e = (k == 0) ? q1[0] : q2[0];
      expv = has && (e.due == cycle);
      if (v || expv) check((k == 0) ? "rd_valid lat1" : "rd_valid lat2", 32'(v), 32'(expv));
      if (expv) begin
        if (v) begin
          check((k == 0) ? "rd_data lat1" : "rd_data lat2", 32'(d), 32'(e.data));
          last_d[k] = e.data;
        end
        if (k == 0) void'(q1.pop_front());
        else        void'(q2.pop_front());
      end else if (!v) begin
        check((k == 0) ? "rd_data hold lat1" : "rd_data hold lat2", 32'(d), 32'(last_d[k]));
      end
    end
  endtask

  task automatic write_frame(input logic [PB-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = base + PB'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_done(input logic w, input logic r);
    wr_frame_done = w;
    rd_frame_done = r;
    tick();
    wr_frame_done = 1'b0;
    rd_frame_done = 1'b0;
  endtask

  task automatic read_one(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    cycle     = 0;
    reset         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    wr_en         = 1'b0;
    wr_frame_done = 1'b0;
    rd_addr       = '0;
    rd_en         = 1'b0;
    rd_frame_done = 1'b0;
    model_reset();

    // Reset state
    repeat (2) tick();
    check("reset frames_stored", 32'(frames_stored1), 32'd0);
    check("reset wr_ready", 32'(wr_ready1), 32'd1);
    check("reset rd_frame_valid", 32'(rd_frame_valid1), 32'd0);
    check("reset rd_valid", 32'(rd_valid2), 32'd0);
    check("reset rd_data", 32'(rd_data2), 32'd0);
    check("reset wr_drop_cnt", 32'(wr_drop_cnt2), 32'd0);
    reset = 1'b1;
    tick();

    // Fill bank 0, commit, read back one pixel, and exercise out-of-range accesses
    write_frame(8'h10);
    pulse_done(1'b1, 1'b0);
    check("t1 frames_stored", 32'(frames_stored1), 32'd1);
    check("t1 rd_frame_valid", 32'(rd_frame_valid1), 32'd1);
    read_one(3);
    check("t1 last rd_data", 32'(rd_data1), 32'h13);
    wr_en = 1'b1; wr_addr = AW'(12); wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("oor write not counted", 32'(wr_drop_cnt1), 32'd0);
    read_one(12);
    check("oor read data", 32'(rd_data1), 32'd0);

    // Fill bank 1 to full, then writes while full are dropped and counted
    write_frame(8'h20);
    pulse_done(1'b1, 1'b0);
    check("t2 frames_stored", 32'(frames_stored1), 32'd2);
    check("t2 wr_ready", 32'(wr_ready1), 32'd0);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'hEE;
      tick();
    end
    wr_en = 1'b0;
    check("t2 wr_drop_cnt", 32'(wr_drop_cnt1), 32'd5);
    pulse_done(1'b1, 1'b0);
    check("t2 commit at full ignored", 32'(frames_stored1), 32'd2);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      tick();
    end
    rd_en = 1'b0;
    repeat (3) tick();

    // At full: commit and release together, so only the release applies
    pulse_done(1'b1, 1'b1);
    check("t3 frames_stored", 32'(frames_stored1), 32'd1);
    read_one(3);
    check("t3 rd_bank 1 data", 32'(rd_data1), 32'h23);

    // One frame stored: commit and release together, and both pointers advance
    write_frame(8'h30);
    pulse_done(1'b1, 1'b1);
    check("t4 frames_stored", 32'(frames_stored1), 32'd1);
    read_one(5);
    check("t4 new frame data", 32'(rd_data2), 32'h35);

    // Back-to-back reads with a release on the second beat
    write_frame(8'h40);
    pulse_done(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      rd_frame_done = (i == 1);
      tick();
    end
    rd_en = 1'b0;
    rd_frame_done = 1'b0;
    repeat (3) tick();
    check("t5 frames_stored", 32'(frames_stored1), 32'd1);

    // Asynchronous reset while the read pipeline is busy
    rd_en = 1'b1; rd_addr = AW'(1);
    tick();
    rd_addr = AW'(2);
    tick();
    rd_en = 1'b0;
    check("t6 pipeline busy", 32'(rd_valid2), 32'd1);
    reset = 1'b0;
    #1;
    check("t6 async rd_valid lat1", 32'(rd_valid1), 32'd0);
    check("t6 async rd_valid lat2", 32'(rd_valid2), 32'd0);
    check("t6 async rd_data lat2", 32'(rd_data2), 32'd0);
    check("t6 async rd_data lat1", 32'(rd_data1), 32'd0);
    check("t6 async frames_stored", 32'(frames_stored1), 32'd0);
    model_reset();
    tick();
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = AW'(12); wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    check("t6 oor write ignored", 32'(wr_drop_cnt1), 32'd0);
    check("t6 frames_stored", 32'(frames_stored2), 32'd0);
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    pulse_done(1'b1, 1'b0);
    read_one(0);
    check("t6 bank0 after reset", 32'(rd_data1), 32'h55);
    repeat (2) tick();
    check("scoreboard drained lat1", 32'(q1.size()), 32'd0);
    check("scoreboard drained lat2", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
